// File: rtl/hamming_pkg.sv
// Hamming(7,4) shared definitions.
// Code positions are numbered 1..7 (p1 p2 d1 p4 d2 d3 d4) and message bits
// 1..4 (d1..d4), so vectors are declared [1:N] to keep index == position.
package hamming_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned CODE_W = 7;

  // Positions covered by each parity bit; bit i of the mask is position i.
  localparam logic [1:CODE_W] P1_MASK = 7'b1010101; // 1,3,5,7
  localparam logic [1:CODE_W] P2_MASK = 7'b0110011; // 2,3,6,7
  localparam logic [1:CODE_W] P4_MASK = 7'b0001111; // 4,5,6,7

  // Place data bits, then fill each parity position from its coverage set.
  // Parity positions still hold 0 when they are folded in, so they do not
  // disturb each other.
  function automatic logic [1:CODE_W] hamming_encode(input logic [1:DATA_W] m);
    logic [1:CODE_W] c;
    c    = '0;
    c[3] = m[1];
    c[5] = m[2];
    c[6] = m[3];
    c[7] = m[4];
    c[1] = ^(c & P1_MASK);
    c[2] = ^(c & P2_MASK);
    c[4] = ^(c & P4_MASK);
    return c;
  endfunction

  // Returns {s4, s2, s1}: the binary position of a single flipped bit.
  function automatic logic [2:0] hamming_syndrome(input logic [1:CODE_W] c);
    return {^(c & P4_MASK), ^(c & P2_MASK), ^(c & P1_MASK)};
  endfunction

endpackage

// File: rtl/hamming_corrector.sv
// Combinational single-error corrector for Hamming(7,4).
// Ports:
//   rx_code_i   [1:7] received word, positions 1..7
//   syndrome_i  [2:0] {s4,s2,s1}; non-zero value k marks position k as wrong
//   corrected_o [1:7] received word with position k flipped
//   data_o      [1:4] d1..d4 taken from the corrected word
module hamming_corrector
  import hamming_pkg::*;
(
  input  logic [1:CODE_W] rx_code_i,
  input  logic [2:0]      syndrome_i,
  output logic [1:CODE_W] corrected_o,
  output logic [1:DATA_W] data_o
);

  always_comb begin
    corrected_o = rx_code_i;
    for (int i = 1; i <= int'(CODE_W); i++) begin
      corrected_o[i] = rx_code_i[i] ^ (syndrome_i == 3'(i));
    end
  end

  assign data_o = {corrected_o[3], corrected_o[5], corrected_o[6], corrected_o[7]};

endmodule

// File: rtl/hamming_code.sv
// Registered Hamming(7,4) encoder and single-error-correcting decoder.
// Encode and decode paths are independent, each with one cycle of latency.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   msg_valid, msg      encode request, d1..d4 in msg[1..4]
//   code_valid, code    one-cycle pulse with codeword p1 p2 d1 p4 d2 d3 d4
//   rx_valid, rx_code   decode request, received word in positions 1..7
//   rx_msg_valid        one-cycle pulse qualifying the decode outputs
//   rx_msg              corrected d1..d4
//   rx_syndrome         {s4,s2,s1}, 0 when the word was clean
//   rx_err              high when a bit was corrected
module hamming_code
  import hamming_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              msg_valid,
  input  logic [1:DATA_W]   msg,
  output logic              code_valid,
  output logic [1:CODE_W]   code,
  input  logic              rx_valid,
  input  logic [1:CODE_W]   rx_code,
  output logic              rx_msg_valid,
  output logic [1:DATA_W]   rx_msg,
  output logic [2:0]        rx_syndrome,
  output logic              rx_err
);

  logic [1:CODE_W] code_q;
  logic            code_valid_q;
  logic [1:DATA_W] rx_msg_q;
  logic [2:0]      rx_syndrome_q;
  logic            rx_err_q;
  logic            rx_msg_valid_q;

  logic [2:0]      syndrome_d;
  logic [1:CODE_W] corrected_d;
  logic [1:DATA_W] data_d;
  logic            err_d;

  assign syndrome_d = hamming_syndrome(rx_code);

  hamming_corrector u_corrector (
    .rx_code_i   (rx_code),
    .syndrome_i  (syndrome_d),
    .corrected_o (corrected_d),
    .data_o      (data_d)
  );

  // Every non-zero syndrome maps to exactly one position, so "a bit was
  // flipped" is equivalent to "syndrome is non-zero".
  assign err_d = |(corrected_d ^ rx_code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q         <= '0;
      code_valid_q   <= 1'b0;
      rx_msg_q       <= '0;
      rx_syndrome_q  <= '0;
      rx_err_q       <= 1'b0;
      rx_msg_valid_q <= 1'b0;
    end else begin
      code_valid_q   <= msg_valid;
      rx_msg_valid_q <= rx_valid;
      if (msg_valid) begin
        code_q <= hamming_encode(msg);
      end
      if (rx_valid) begin
        rx_msg_q      <= data_d;
        rx_syndrome_q <= syndrome_d;
        rx_err_q      <= err_d;
      end
    end
  end

  assign code         = code_q;
  assign code_valid   = code_valid_q;
  assign rx_msg       = rx_msg_q;
  assign rx_syndrome  = rx_syndrome_q;
  assign rx_err       = rx_err_q;
  assign rx_msg_valid = rx_msg_valid_q;

endmodule

// File: tb/tb_hamming_code.sv
// Scoreboard bench for hamming_code: expected results are queued when
// stimulus is driven and popped when the matching valid pulse appears.
module tb_hamming_code;

  typedef struct packed {
    logic [1:4] msg;
    logic [2:0] syn;
    logic       err;
  } dec_exp_t;

  logic       clk;
  logic       rst_n;
  logic       msg_valid;
  logic [1:4] msg;
  logic       code_valid;
  logic [1:7] code;
  logic       rx_valid;
  logic [1:7] rx_code;
  logic       rx_msg_valid;
  logic [1:4] rx_msg;
  logic [2:0] rx_syndrome;
  logic       rx_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [1:7] enc_q[$];
  dec_exp_t   dec_q[$];

  hamming_code dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .msg_valid    (msg_valid),
    .msg          (msg),
    .code_valid   (code_valid),
    .code         (code),
    .rx_valid     (rx_valid),
    .rx_code      (rx_code),
    .rx_msg_valid (rx_msg_valid),
    .rx_msg       (rx_msg),
    .rx_syndrome  (rx_syndrome),
    .rx_err       (rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference encoder written straight from the parity equations.
  function automatic logic [1:7] enc_model(input logic [1:4] m);
    logic d1, d2, d3, d4;
    d1 = m[1]; d2 = m[2]; d3 = m[3]; d4 = m[4];
    return {d1 ^ d2 ^ d4, d1 ^ d3 ^ d4, d1, d2 ^ d3 ^ d4, d2, d3, d4};
  endfunction

  function automatic logic [1:7] flip_at(input logic [1:7] w, input int pos);
    logic [1:7] r;
    r = w;
    if (pos != 0) r[pos] = ~r[pos];
    return r;
  endfunction

  // Drive one cycle of stimulus at the falling edge and queue expectations.
  // For decode, the expected message and error position are the ones used to
  // build rx word, not anything derived from it.
  task automatic drive(input logic mv, input logic [1:4] m,
                       input logic rv, input logic [1:4] rm, input int pos);
    dec_exp_t e;
    @(negedge clk);
    msg_valid = mv;
    msg       = m;
    rx_valid  = rv;
    rx_code   = flip_at(enc_model(rm), pos);
    if (mv) enc_q.push_back(enc_model(m));
    if (rv) begin
      e.msg = rm;
      e.syn = 3'(pos);
      e.err = (pos != 0);
      dec_q.push_back(e);
    end
  endtask

  task automatic idle();
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 0);
  endtask

  // Monitor: sample just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (code_valid) begin
      if (enc_q.size() == 0) begin
        check_eq("enc_spurious_valid", 32'(code_valid), 32'd0);
      end else begin
        check_eq("enc_code", 32'(code), 32'(enc_q.pop_front()));
      end
    end
    if (rx_msg_valid) begin
      if (dec_q.size() == 0) begin
        check_eq("dec_spurious_valid", 32'(rx_msg_valid), 32'd0);
      end else begin
        dec_exp_t e;
        e = dec_q.pop_front();
        check_eq("dec_msg", 32'(rx_msg), 32'(e.msg));
        check_eq("dec_syn", 32'(rx_syndrome), 32'(e.syn));
        check_eq("dec_err", 32'(rx_err), 32'(e.err));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_code"}, 32'(code), 32'd0);
    check_eq({tag, "_code_valid"}, 32'(code_valid), 32'd0);
    check_eq({tag, "_rx_msg"}, 32'(rx_msg), 32'd0);
    check_eq({tag, "_rx_syn"}, 32'(rx_syndrome), 32'd0);
    check_eq({tag, "_rx_err"}, 32'(rx_err), 32'd0);
    check_eq({tag, "_rx_msg_valid"}, 32'(rx_msg_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    msg_valid = 1'b0;
    msg       = '0;
    rx_valid  = 1'b0;
    rx_code   = '0;
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed encode: 1011 -> 0110011, then hold with valid low.
    drive(1'b1, 4'b1011, 1'b0, 4'b0000, 0);
    idle();
    // negedge after rising edge that captured the request: check output
    check_eq("enc_1011_code", 32'(code), 32'h33);
    check_eq("enc_1011_valid", 32'(code_valid), 32'd1);
    idle();
    check_eq("enc_hold_code", 32'(code), 32'h33);
    check_eq("enc_hold_valid", 32'(code_valid), 32'd0);

    drive(1'b1, 4'b0000, 1'b0, 4'b0000, 0);
    drive(1'b1, 4'b1111, 1'b0, 4'b0000, 0);
    check_eq("enc_0000_code", 32'(code), 32'h00);
    idle();
    check_eq("enc_1111_code", 32'(code), 32'h7f);

    // Directed decode: clean word and bit 5 flipped.
    drive(1'b0, 4'b0000, 1'b1, 4'b1011, 0);
    idle();
    check_eq("dec_clean_rx_code", 32'(rx_msg), 32'hb);
    check_eq("dec_clean_syn", 32'(rx_syndrome), 32'd0);
    check_eq("dec_clean_err", 32'(rx_err), 32'd0);
    drive(1'b0, 4'b0000, 1'b1, 4'b1011, 5);
    idle();
    check_eq("dec_bit5_msg", 32'(rx_msg), 32'hb);
    check_eq("dec_bit5_syn", 32'(rx_syndrome), 32'd5);
    check_eq("dec_bit5_err", 32'(rx_err), 32'd1);
    idle();
    check_eq("dec_hold_syn", 32'(rx_syndrome), 32'd5);
    check_eq("dec_hold_valid", 32'(rx_msg_valid), 32'd0);

    // Exhaustive single-error sweep, back to back, alongside encodes.
    for (int m = 0; m < 16; m++) begin
      for (int p = 0; p < 8; p++) begin
        drive(1'b1, 4'(m), 1'b1, 4'(m), p);
      end
    end
    idle();
    idle();

    // Random stream with both valids every cycle, then reset mid-stream.
    for (int n = 0; n < 20; n++) begin
      drive(1'b1, 4'($urandom), 1'b1, 4'($urandom), int'($urandom_range(0, 7)));
    end
    #2;
    rst_n = 1'b0;
    msg_valid = 1'b0;
    rx_valid  = 1'b0;
    enc_q.delete();
    dec_q.delete();
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("post_reset");

    // One more transaction after release to show the paths resume.
    drive(1'b1, 4'b0110, 1'b1, 4'b1001, 3);
    idle();
    idle();

    check_eq("enc_pending", 32'(enc_q.size()), 32'd0);
    check_eq("dec_pending", 32'(dec_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hamming_code.md
Name: hamming_code

Overview:
- Registered Hamming(7,4) single-error-correcting codec.
- Encode path: a 4-bit message becomes a 7-bit codeword.
- Decode path: a received 7-bit word is checked, its syndrome is computed, any single-bit error is corrected, and the 4 data bits are extracted.
- Sits between a data source and a noisy link or storage element. One clock domain.

Parameters:
- None. Widths are fixed at 4 data bits and 7 code bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- msg_valid  input  1  msg is valid this cycle; qualifies an encode.
- msg  input  [1:4]  message bits d1..d4; msg[1] is d1.
- code_valid  output  1  code holds a new codeword; one-cycle pulse.
- code  output  [1:7]  codeword, positions 1..7 = p1 p2 d1 p4 d2 d3 d4.
- rx_valid  input  1  rx_code is valid this cycle.
- rx_code  input  [1:7]  received word, same position order as code.
- rx_msg_valid  output  1  decode result valid; one-cycle pulse.
- rx_msg  output  [1:4]  corrected data d1..d4.
- rx_syndrome  output  [2:0]  {s4,s2,s1}; binary position of the errored bit, 0 means no error.
- rx_err  output  1  high when rx_syndrome is non-zero.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are cleared immediately.
  - code = 0, code_valid = 0.
  - rx_msg = 0, rx_syndrome = 0, rx_err = 0, rx_msg_valid = 0.
- Encode parity, with d1..d4 = msg[1..4]:
  - p1 = d1^d2^d4
  - p2 = d1^d3^d4
  - p4 = d2^d3^d4
- Encode latency and hold:
  - Latency is 1 cycle. code and code_valid register on the edge where msg_valid = 1.
  - code_valid is high for exactly one cycle per accepted message.
  - When msg_valid = 0, code holds its last value and code_valid = 0.
- Decode syndrome, with c1..c7 = rx_code[1..7]:
  - s1 = c1^c3^c5^c7
  - s2 = c2^c3^c6^c7
  - s4 = c4^c5^c6^c7
- Decode correction:
  - A non-zero syndrome k flips bit ck before extraction.
  - rx_msg = {c3, c5, c6, c7} after correction.
  - An error in a parity position (1, 2 or 4) leaves the data unchanged but still sets rx_err.
- Decode latency and hold:
  - Latency is 1 cycle. rx_msg, rx_syndrome and rx_err register together with rx_msg_valid.
  - When rx_valid = 0, all decode outputs hold and rx_msg_valid = 0.
- Double-bit errors are undetectable by design. They produce a miscorrection with rx_err = 1; no detection is required.
- The encode and decode paths are fully independent. Simultaneous msg_valid and rx_valid are both serviced in the same cycle. Back-to-back valids every cycle are supported, with no throughput limit.
- Reset asserted mid-stream: an in-flight result is discarded. Outputs return to zero and valids are low on the first edge after release until the next input.

Decomposition:
- Shared package hamming_pkg:
  - localparams for DATA_W = 4 and CODE_W = 7.
  - Parity-coverage masks: P1_MASK = positions 1,3,5,7; P2_MASK = 2,3,6,7; P4_MASK = 4,5,6,7.
  - Pure functions hamming_encode and hamming_syndrome.
- One sub-module, hamming_corrector (combinational): takes the received word and syndrome, returns the corrected word and extracted data.
- The top level holds the registers only.

Test Plan:
- msg = 4'b1011, msg_valid = 1 for one cycle -> next cycle code = 7'b0110011, code_valid = 1 for 1 cycle, then 0 while code holds.
- msg = 4'b0000 -> code = 7'b0000000; msg = 4'b1111 -> code = 7'b1111111.
- rx_code = 7'b0110011 (clean) -> rx_msg = 4'b1011, rx_syndrome = 3'd0, rx_err = 0.
- rx_code = 7'b0110111 (bit 5 flipped) -> rx_syndrome = 3'd5, rx_err = 1, rx_msg = 4'b1011.
  - Loop: all 16 messages × 8 error positions (0 = none) -> rx_msg always equals the original message and rx_syndrome equals the flipped position.
- Both valids asserted every cycle for 20 cycles, then rst_n pulsed low mid-stream -> all outputs go to 0 asynchronously (before the next edge), and no valid appears until new input arrives after release.
